rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter with grant locking and a hold timeout.
- Produces a registered one-hot grant and its 2-bit encoded index. The index replaces the combinational 4-to-2 encoder at the arbitration point.
- Shares a single downstream resource (a bus or a functional unit) among four requesters.
- Sits between the requester blocks and the shared resource's select/mux input.

---
 rtl/rr_arbiter4.sv | 91 +++++++++
 tb/tb_rr_arbiter4.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold timeout; registered one-hot grant plus index.
// Latency: 1 cycle req->gnt; no backpressure, requests are sampled each edge and never latched.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       tmo
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [1:0] base;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       hold_last;

    // On a release or timeout the search starts just past the owner, so the owner
    // itself is only chosen last, i.e. re-granted only when nobody else is asking.
    always_comb begin
        base       = (state == GRANT) ? gnt_idx + 2'd1 : ptr;
        pick_found = 1'b0;
        pick_idx   = base;
        for (int i = 3; i >= 0; i--) begin
            if (req[base + 2'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = base + 2'(i);
            end
        end
    end

    assign owner_req = req[gnt_idx];
    assign hold_last = (hold_cnt == CNT_W'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            tmo <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << pick_idx;
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (owner_req && !hold_last) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        ptr <= gnt_idx + 2'd1;
                        tmo <= owner_req;
                        if (pick_found) begin
                            gnt       <= 4'b0001 << pick_idx;
                            gnt_idx   <= pick_idx;
                            gnt_valid <= 1'b1;
                            hold_cnt  <= '0;
                        end else begin
                            state     <= IDLE;
                            gnt       <= 4'b0000;
                            gnt_idx   <= 2'd0;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (HOLD_MAX=8); expected outputs queued per step and checked after the edge.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       tmo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       tmo;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter4 #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Drive one cycle of stimulus, queue the hand-derived expectation, then compare after the edge.
    task automatic step(input logic [3:0] r, input logic rs, input logic [3:0] eg,
                        input logic et, input string tag);
        exp_t e;
        req = r;
        rst = rs;
        e.gnt = eg;
        e.idx = onehot_idx(eg);
        e.vld = |eg;
        e.tmo = et;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (gnt === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt: got %b want %b", e.tag, gnt, e.gnt);
        end
        checks++;
        assert (gnt_idx === e.idx) else begin
            errors++;
            $error("FAIL %s gnt_idx: got %0d want %0d", e.tag, gnt_idx, e.idx);
        end
        checks++;
        assert (gnt_valid === e.vld) else begin
            errors++;
            $error("FAIL %s gnt_valid: got %b want %b", e.tag, gnt_valid, e.vld);
        end
        checks++;
        assert (tmo === e.tmo) else begin
            errors++;
            $error("FAIL %s tmo: got %b want %b", e.tag, tmo, e.tmo);
        end
    endtask

    initial begin
        req = 4'b0000;
        rst = 1'b1;
        #1;

        // Reset held with all requests up
        step(4'b1111, 1'b1, 4'b0000, 1'b0, "reset0");
        step(4'b1111, 1'b1, 4'b0000, 1'b0, "reset1");
        step(4'b1111, 1'b0, 4'b0001, 1'b0, "first_grant");

        // Round robin: each owner drops its request for one cycle
        step(4'b1110, 1'b0, 4'b0010, 1'b0, "rr_1");
        step(4'b1101, 1'b0, 4'b0100, 1'b0, "rr_2");
        step(4'b1011, 1'b0, 4'b1000, 1'b0, "rr_3");
        step(4'b0111, 1'b0, 4'b0001, 1'b0, "rr_0");
        step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_hold");

        // Release with no other requester -> idle (ptr becomes 1)
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_idle");

        // Single requester for three cycles, then drop (ptr becomes 3)
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 4'b0100, 1'b0, "single");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "single_drop");

        // Two requesters held: 8 cycles each, timeout pulse on each switch
        for (int i = 0; i < 8; i++) step(4'b0011, 1'b0, 4'b0001, 1'b0, "tmo_own0");
        step(4'b0011, 1'b0, 4'b0010, 1'b1, "tmo_sw1");
        for (int i = 0; i < 7; i++) step(4'b0011, 1'b0, 4'b0010, 1'b0, "tmo_own1");
        step(4'b0011, 1'b0, 4'b0001, 1'b1, "tmo_sw0");
        step(4'b0011, 1'b0, 4'b0001, 1'b0, "tmo_after");

        // Lone owner: grant stays, tmo pulses every 8 cycles
        step(4'b1000, 1'b0, 4'b1000, 1'b0, "lone_start");
        for (int i = 0; i < 7; i++) step(4'b1000, 1'b0, 4'b1000, 1'b0, "lone_hold_a");
        step(4'b1000, 1'b0, 4'b1000, 1'b1, "lone_tmo_a");
        for (int i = 0; i < 7; i++) step(4'b1000, 1'b0, 4'b1000, 1'b0, "lone_hold_b");
        step(4'b1000, 1'b0, 4'b1000, 1'b1, "lone_tmo_b");

        // Mid-grant reset
        step(4'b0010, 1'b0, 4'b0010, 1'b0, "pre_rst_gnt1");
        step(4'b1111, 1'b1, 4'b0000, 1'b0, "mid_rst");
        step(4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
